// File: rtl/fxp_divider.sv
// fxp_divider: signed fixed-point divider (QX.FBITS / QX.FBITS -> QX.FBITS).
// Restoring shift-subtract on operand magnitudes, one quotient bit per clock,
// followed by sign application and saturation.
// Optional build macro FXP_DIVIDER_ROUND_EN: computes one extra guard bit and
// rounds the magnitude half away from zero (latency +1). When it is not defined,
// the quotient truncates toward zero.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; results and flags hold their last values
// CALC  | one restoring shift-subtract step per cycle; cnt_q counts down
// FIN   | sign, saturation and flags applied; done registered for one cycle
module fxp_divider #(
    parameter int WIDTH = 24,
    parameter int FBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] val
);

`ifdef FXP_DIVIDER_ROUND_EN
    localparam int NQ = WIDTH + FBITS + 1;
`else
    localparam int NQ = WIDTH + FBITS;
`endif
    localparam int MW = WIDTH + FBITS;
    localparam int CW = $clog2(NQ + 1);
    localparam int SH = NQ - WIDTH;

    // Largest legal magnitudes for positive and negative results.
    localparam logic [MW-1:0] POS_LIM = {{(FBITS + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM = {{FBITS{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [NQ-1:0]    dq_q;
    logic             sign_q;
    logic             zdiv_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [MW-1:0]    q_mag;
    logic             sat_pos, sat_neg;
    logic [WIDTH-1:0] res_mag, res_s;

    // Magnitudes are WIDTH-bit unsigned so the most negative input survives.
    assign a_mag = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    assign b_mag = b[WIDTH-1] ? (WIDTH'(0) - b) : b;

    // Restoring step: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits. When it fits the difference is below
    // 2^WIDTH, so a WIDTH-bit subtraction is exact.
    always_comb begin
        trial  = {rem_q, dq_q[NQ-1]};
        ge     = (trial >= {1'b0, dvsr_q});
        rem_nx = ge ? (trial[WIDTH-1:0] - dvsr_q) : trial[WIDTH-1:0];
    end

    // Final magnitude (optionally rounded), saturation detection and signing.
    always_comb begin
`ifdef FXP_DIVIDER_ROUND_EN
        q_mag = dq_q[NQ-1:1] + MW'(dq_q[0]);
`else
        q_mag = dq_q;
`endif
        sat_pos = !sign_q && (q_mag > POS_LIM);
        sat_neg = sign_q && (q_mag > NEG_LIM);
        res_mag = q_mag[WIDTH-1:0];
        res_s   = sign_q ? (WIDTH'(0) - res_mag) : res_mag;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a zero divisor skips CALC entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (b == '0) ? FIN : CALC;
            CALC: if (cnt_q == '0) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvsr_q <= '0;
            rem_q  <= '0;
            dq_q   <= '0;
            sign_q <= 1'b0;
            zdiv_q <= 1'b0;
            cnt_q  <= '0;
            done   <= 1'b0;
            valid  <= 1'b0;
            dbz    <= 1'b0;
            ovf    <= 1'b0;
            val    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        valid  <= 1'b0;
                        dbz    <= 1'b0;
                        ovf    <= 1'b0;
                        zdiv_q <= (b == '0);
                        dvsr_q <= b_mag;
                        rem_q  <= '0;
                        dq_q   <= {a_mag, {SH{1'b0}}};
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        cnt_q  <= CW'(NQ - 1);
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    dq_q  <= {dq_q[NQ-2:0], ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIN: begin
                    done <= 1'b1;
                    if (zdiv_q) begin
                        dbz   <= 1'b1;
                        valid <= 1'b0;
                        ovf   <= 1'b0;
                        val   <= '0;
                    end else if (sat_pos) begin
                        ovf   <= 1'b1;
                        valid <= 1'b0;
                        val   <= {1'b0, {(WIDTH - 1){1'b1}}};
                    end else if (sat_neg) begin
                        ovf   <= 1'b1;
                        valid <= 1'b0;
                        val   <= {1'b1, {(WIDTH - 1){1'b0}}};
                    end else begin
                        valid <= 1'b1;
                        ovf   <= 1'b0;
                        dbz   <= 1'b0;
                        val   <= res_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_divider.sv
// tb_fxp_divider: directed vectors with a scoreboard queue; a monitor pops an
// expected result on every done pulse and checks value, flags and latency.
`timescale 1ns/1ps
module tb_fxp_divider;
    localparam int WIDTH = 24;
    localparam int FBITS = 8;
`ifdef FXP_DIVIDER_ROUND_EN
    localparam int NLAT = WIDTH + FBITS + 1 + 2;
    localparam logic [23:0] Q23P = 24'h0000AB;
    localparam logic [23:0] Q23N = 24'hFFFF55;
`else
    localparam int NLAT = WIDTH + FBITS + 2;
    localparam logic [23:0] Q23P = 24'h0000AA;
    localparam logic [23:0] Q23N = 24'hFFFF56;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        busy, done, valid, dbz, ovf;
    logic [23:0] val;

    typedef struct {
        logic [23:0] val;
        logic        valid;
        logic        dbz;
        logic        ovf;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    fxp_divider #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .dbz   (dbz),
        .ovf   (ovf),
        .val   (val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_val"},   32'(val),   32'(mon_e.val));
                chk({mon_e.name, "_valid"}, 32'(valid), 32'(mon_e.valid));
                chk({mon_e.name, "_dbz"},   32'(dbz),   32'(mon_e.dbz));
                chk({mon_e.name, "_ovf"},   32'(ovf),   32'(mon_e.ovf));
                chk({mon_e.name, "_lat"},   32'(cyc),   32'(mon_e.due));
            end
        end
    end

    // Drive one accepted start and push its expected outcome.
    task automatic issue(input string name, input logic [23:0] ta, input logic [23:0] tbv,
                         input logic [23:0] ev, input logic ev_valid, input logic ev_dbz,
                         input logic ev_ovf);
        exp_t e;
        @(negedge clk);
        a = ta;
        b = tbv;
        start = 1'b1;
        e.val = ev;
        e.valid = ev_valid;
        e.dbz = ev_dbz;
        e.ovf = ev_ovf;
        e.due = cyc + ((tbv == 24'h0) ? 2 : NLAT);
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = 24'h000001;
        chk({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Wait until the scoreboard drains, then confirm outputs hold.
    task automatic finish_op(input string name, input logic [23:0] ev);
        int k = 0;
        while ((sb.size() != 0 || busy === 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, k);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk({name, "_hold"}, 32'(val), 32'(ev));
    endtask

    task automatic op(input string name, input logic [23:0] ta, input logic [23:0] tbv,
                      input logic [23:0] ev, input logic ev_valid, input logic ev_dbz,
                      input logic ev_ovf);
        issue(name, ta, tbv, ev, ev_valid, ev_dbz, ev_ovf);
        finish_op(name, ev);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"},  32'(busy),  32'd0);
        chk({name, "_done"},  32'(done),  32'd0);
        chk({name, "_valid"}, 32'(valid), 32'd0);
        chk({name, "_dbz"},   32'(dbz),   32'd0);
        chk({name, "_ovf"},   32'(ovf),   32'd0);
        chk({name, "_val"},   32'(val),   32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        op("div10_2",  24'h000A00, 24'h000200, 24'h000500, 1'b1, 1'b0, 1'b0);
        op("div2_3",   24'h000200, 24'h000300, Q23P,        1'b1, 1'b0, 1'b0);
        op("divm2_3",  24'hFFFE00, 24'h000300, Q23N,        1'b1, 1'b0, 1'b0);
        op("negneg",   24'hFFF600, 24'hFFFE00, 24'h000500, 1'b1, 1'b0, 1'b0);
        op("dbz",      24'h000A00, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0);
        op("ovf_neg",  24'h800000, 24'h000080, 24'h800000, 1'b0, 1'b0, 1'b1);
        op("ovf_pos",  24'h7FFFFF, 24'h000080, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
        op("ovf_mm",   24'h800000, 24'hFFFF00, 24'h7FFFFF, 1'b0, 1'b0, 1'b1);
        op("negbound", 24'h800000, 24'h000100, 24'h800000, 1'b1, 1'b0, 1'b0);
        op("zero_neg", 24'hFFFFFF, 24'h7FFFFF, 24'h000000, 1'b1, 1'b0, 1'b0);
        op("zero_a",   24'h000000, 24'hFFFF00, 24'h000000, 1'b1, 1'b0, 1'b0);

        // start pulses while busy must be ignored (a second done would be flagged).
        issue("busy_ign", 24'h000A00, 24'h000200, 24'h000500, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            a = 24'h123456;
            b = 24'h000300;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        finish_op("busy_ign", 24'h000500);

        // Reset ten cycles into CALC: operation discarded, no done pulse.
        @(negedge clk);
        a = 24'h000200;
        b = 24'h000300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst_mid");
        repeat (NLAT + 5) @(negedge clk);
        chk("rst_mid_quiet", 32'(busy), 32'd0);
        op("after_rst", 24'h000A00, 24'h000200, 24'h000500, 1'b1, 1'b0, 1'b0);

        // Reset together with start: start ignored.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 24'h000A00;
        b = 24'h000200;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk_all_zero("rst_start");
        repeat (NLAT + 5) @(negedge clk);
        chk("rst_start_quiet", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fxp_divider.md
FXP_DIVIDER -- requirements
Module: fxp_divider

Interface
REQ-001 Parameter WIDTH, default 24, total signed fixed-point word width in bits (two's complement).
REQ-002 Parameter FBITS, default 8, fractional bits; legal range 1 <= FBITS < WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  signed dividend, QX.FBITS; captured on the accepted start.
REQ-007 b  input  WIDTH  signed divisor, QX.FBITS; captured on the accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking result delivery.
REQ-010 valid  output  1  result is exact or rounded; low on dbz or ovf; held until the next accepted start.
REQ-011 dbz  output  1  divide-by-zero flag; held until the next accepted start.
REQ-012 ovf  output  1  overflow/saturation flag; held until the next accepted start.
REQ-013 val  output  WIDTH  signed quotient, QX.FBITS; held until the next accepted start.

Function
REQ-014 States SHALL be IDLE, CALC, FIN; reset state is IDLE.
REQ-015 In IDLE with start=1 and b!=0, the block SHALL capture |a|, |b| and the result sign (sign(a) XOR sign(b)), clear valid/dbz/ovf, and enter CALC.
REQ-016 In IDLE with start=1 and b==0, the block SHALL enter FIN directly, skipping CALC; FIN then drives dbz=1, valid=0, ovf=0, val=0 and pulses done.
REQ-017 CALC SHALL run restoring shift-subtract on the unsigned dividend |a|<<FBITS, one quotient bit per cycle, for N = WIDTH+FBITS iterations (N+1 with the rounding macro).
REQ-018 Operand magnitudes SHALL be WIDTH-bit unsigned, so |-2^(WIDTH-1)| is represented without loss.
REQ-019 The last CALC iteration SHALL move the block to FIN; FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-020 Latency: for start sampled at edge k, done SHALL be high in the cycle after edge k+N+1; for b==0, in the cycle after edge k+1.
REQ-021 busy SHALL be high in CALC and FIN and low in IDLE.
REQ-022 start while busy SHALL be ignored; the a and b inputs SHALL NOT affect an operation in flight.
REQ-023 For a positive result, magnitude > 2^(WIDTH-1)-1 SHALL saturate: val=2^(WIDTH-1)-1, ovf=1, valid=0.
REQ-024 For a negative result, magnitude > 2^(WIDTH-1) SHALL saturate: val=-2^(WIDTH-1), ovf=1, valid=0; magnitude exactly 2^(WIDTH-1) is legal.
REQ-025 Otherwise val SHALL be the magnitude with the sign applied; valid=1, dbz=0, ovf=0.
REQ-026 A zero quotient SHALL yield val=0 regardless of sign; it is never -0.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and clear busy, done, valid, dbz, ovf and val to 0, including mid-CALC; the in-flight operation is discarded with no done pulse.
REQ-028 rst=1 together with start=1 SHALL ignore start.

Configuration
REQ-029 Macro FXP_DIVIDER_ROUND_EN defined: CALC computes one guard bit, and magnitude rounds half away from zero before the saturation check; latency N=WIDTH+FBITS+1.
REQ-030 Macro FXP_DIVIDER_ROUND_EN undefined: the quotient truncates toward zero; latency N=WIDTH+FBITS; no guard logic.

Verification (WIDTH=24, FBITS=8)
REQ-031 a=0x000A00, b=0x000200 -> val=0x000500, valid=1; done exactly 34 cycles after start (35 with rounding).
REQ-032 a=0x000200, b=0x000300 -> val=0x0000AA truncated, or 0x0000AB with FXP_DIVIDER_ROUND_EN; a=0xFFFE00 gives 0xFFFF56 / 0xFFFF55.
REQ-033 a=0x000A00, b=0 -> done 2 cycles after start, dbz=1, valid=0, val=0.
REQ-034 a=0x800000, b=0x000080 -> ovf=1, val=0x800000. a=0x7FFFFF, b=0x000080 -> ovf=1, val=0x7FFFFF. a=0x800000, b=0xFFFF00 -> ovf=1, val=0x7FFFFF.
REQ-035 a=0x800000, b=0x000100 -> val=0x800000, valid=1, ovf=0 (negative boundary, no overflow).
REQ-036 rst pulsed 10 cycles into CALC -> no done pulse, all outputs 0; next start with a=0x000A00, b=0x000200 yields 0x000500. start pulses while busy have no effect.
